fft_mag_arbiter: RTL and testbench

Frame-granular round-robin arbiter that shares the single magnitude-squared unit (|re|²+|im|², 1-cycle latency, no back-pressure) between two FFT output streams. Sits between the two FFT cores and the magnitude unit and owns all sequencing. It grants whole frames, issues samples only when result space is guaranteed, and tags each result with channel and bin index. Also reports the per-frame peak bin.

---
 rtl/fft_mag_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_fft_mag_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_mag_arbiter.sv
// Frame-granular round-robin arbiter sharing one magnitude-squared unit between two FFT streams.
// Issues samples only with guaranteed result space, tags results, and reports per-frame peaks.
module fft_mag_arbiter #(
  parameter int unsigned FRAME_LEN  = 256,
  parameter int unsigned IDX_W      = 8,
  parameter int unsigned MUL_LAT    = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [31:0]      i_s0_data,
  input  logic             i_s0_valid,
  output logic             o_s0_ready,
  input  logic [31:0]      i_s1_data,
  input  logic             i_s1_valid,
  output logic             o_s1_ready,
  output logic [31:0]      o_m_data,
  output logic             o_m_valid,
  input  logic [31:0]      i_r_data,
  input  logic             i_r_valid,
  output logic [31:0]      o_data,
  output logic             o_chan,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_last,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_peak_val,
  output logic [IDX_W-1:0] o_peak_idx,
  output logic             o_peak_chan,
  output logic             o_peak_valid,
  output logic             o_err
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned LAT_W = $clog2(MUL_LAT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic             vld;
    logic             chan;
    logic [IDX_W-1:0] idx;
    logic             last;
  } tag_t;

  typedef struct packed {
    logic [31:0]      data;
    logic             chan;
    logic [IDX_W-1:0] idx;
    logic             last;
  } ent_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_served_q, last_served_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  tag_t             tag_q [MUL_LAT];
  tag_t             tag_d [MUL_LAT];
  ent_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      max_q, max_d;
  logic [IDX_W-1:0] max_idx_q, max_idx_d;
  logic [31:0]      peak_val_q, peak_val_d;
  logic [IDX_W-1:0] peak_idx_q, peak_idx_d;
  logic             peak_chan_q, peak_chan_d;
  logic             peak_valid_q, peak_valid_d;
  logic             err_q, err_d;

  logic [LAT_W-1:0] inflight;
  logic             credit_ok, s0_rdy, s1_rdy, hs, push, pop, fifo_vld;
  ent_t             head;

  // Results still inside the multiplier count against FIFO space, so back-pressure can never overflow it.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < MUL_LAT; i++) inflight = inflight + LAT_W'(tag_q[i].vld);
  end
  assign credit_ok = (32'(cnt_q) + 32'(inflight)) < FIFO_DEPTH;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_served_d = last_served_q;
    idx_d         = idx_q;
    s0_rdy        = 1'b0;
    s1_rdy        = 1'b0;
    hs            = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_s0_valid && i_s1_valid) begin
          owner_d = ~last_served_q;
          state_d = BUSY;
        end else if (i_s0_valid || i_s1_valid) begin
          owner_d = i_s1_valid;
          state_d = BUSY;
        end
      end
      BUSY: begin
        s0_rdy = i_rst_n && !owner_q && credit_ok;
        s1_rdy = i_rst_n && owner_q && credit_ok;
        hs     = (s0_rdy && i_s0_valid) || (s1_rdy && i_s1_valid);
        if (hs) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            idx_d         = '0;
            last_served_d = owner_q;
            state_d       = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_s0_ready = s0_rdy;
  assign o_s1_ready = s1_rdy;
  assign o_m_valid  = hs;
  assign o_m_data   = hs ? (owner_q ? i_s1_data : i_s0_data) : '0;

  always_comb begin
    tag_d[0] = '{vld: hs, chan: owner_q, idx: idx_q, last: (idx_q == LAST_IDX)};
    for (int unsigned i = 1; i < MUL_LAT; i++) tag_d[i] = tag_q[i-1];
  end

  assign fifo_vld = (cnt_q != '0);
  assign head     = mem_q[rd_ptr_q];
  assign push     = i_r_valid && tag_q[MUL_LAT-1].vld;
  assign pop      = fifo_vld && i_ready;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
    else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
    err_d = err_q || (i_r_valid && !tag_q[MUL_LAT-1].vld);
  end

  // Running max restarts on bin 0; strict compare keeps the earliest bin on ties.
  always_comb begin
    max_d        = max_q;
    max_idx_d    = max_idx_q;
    peak_val_d   = peak_val_q;
    peak_idx_d   = peak_idx_q;
    peak_chan_d  = peak_chan_q;
    peak_valid_d = 1'b0;
    if (pop) begin
      if (head.idx == '0 || head.data > max_q) begin
        max_d     = head.data;
        max_idx_d = head.idx;
      end
      if (head.last) begin
        peak_val_d   = max_d;
        peak_idx_d   = max_idx_d;
        peak_chan_d  = head.chan;
        peak_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_served_q <= 1'b1;
      idx_q         <= '0;
      for (int unsigned i = 0; i < MUL_LAT; i++) tag_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      max_q         <= '0;
      max_idx_q     <= '0;
      peak_val_q    <= '0;
      peak_idx_q    <= '0;
      peak_chan_q   <= 1'b0;
      peak_valid_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_served_q <= last_served_d;
      idx_q         <= idx_d;
      for (int unsigned i = 0; i < MUL_LAT; i++) tag_q[i] <= tag_d[i];
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      max_q         <= max_d;
      max_idx_q     <= max_idx_d;
      peak_val_q    <= peak_val_d;
      peak_idx_q    <= peak_idx_d;
      peak_chan_q   <= peak_chan_d;
      peak_valid_q  <= peak_valid_d;
      err_q         <= err_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= '{data: i_r_data, chan: tag_q[MUL_LAT-1].chan,
                                   idx: tag_q[MUL_LAT-1].idx, last: tag_q[MUL_LAT-1].last};
  end

  assign o_valid      = fifo_vld;
  assign o_data       = fifo_vld ? head.data : '0;
  assign o_chan       = fifo_vld ? head.chan : 1'b0;
  assign o_idx        = fifo_vld ? head.idx : '0;
  assign o_last       = fifo_vld ? head.last : 1'b0;
  assign o_peak_val   = peak_val_q;
  assign o_peak_idx   = peak_idx_q;
  assign o_peak_chan  = peak_chan_q;
  assign o_peak_valid = peak_valid_q;
  assign o_err        = err_q;
endmodule

// File: tb/tb_fft_mag_arbiter.sv
// Directed bench for fft_mag_arbiter with a behavioural 1-cycle magnitude unit.
module tb_fft_mag_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s0_data, s1_data, m_data, r_data, o_data, peak_val;
  logic        s0_valid, s1_valid, s0_ready, s1_ready, m_valid, r_valid;
  logic        o_chan, o_last, o_valid, i_ready, peak_chan, peak_valid, err;
  logic [7:0]  o_idx, peak_idx;

  logic        r_valid_m = 1'b0;
  logic [31:0] r_data_m = '0;
  logic        spur = 1'b0;

  int checks = 0, failures = 0, cyc = 0;
  int src0_n, src0_tot, src1_n, src1_tot;
  bit peak_mode;
  int pk_cnt;
  logic [31:0] pk_val;
  logic [7:0]  pk_idx;
  logic        pk_chan;

  typedef struct {
    logic [31:0] data;
    logic        chan;
    logic [7:0]  idx;
    logic        last;
    int          cyc;
  } beat_t;
  beat_t obs[$];
  int    hs_cyc[$];

  always #5 clk = ~clk;

  fft_mag_arbiter #(.FRAME_LEN(256), .IDX_W(8), .MUL_LAT(1), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_s0_data(s0_data), .i_s0_valid(s0_valid), .o_s0_ready(s0_ready),
    .i_s1_data(s1_data), .i_s1_valid(s1_valid), .o_s1_ready(s1_ready),
    .o_m_data(m_data), .o_m_valid(m_valid),
    .i_r_data(r_data), .i_r_valid(r_valid),
    .o_data(o_data), .o_chan(o_chan), .o_idx(o_idx), .o_last(o_last),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_peak_val(peak_val), .o_peak_idx(peak_idx), .o_peak_chan(peak_chan),
    .o_peak_valid(peak_valid), .o_err(err)
  );

  function automatic logic [31:0] mag(input logic [31:0] s);
    logic signed [15:0] re, im;
    logic signed [31:0] a, b;
    re = s[15:0];
    im = s[31:16];
    a = re * re;
    b = im * im;
    return 32'(a + b);
  endfunction

  always @(posedge clk) begin
    r_valid_m <= m_valid;
    r_data_m  <= mag(m_data);
  end
  assign r_valid = r_valid_m | spur;
  assign r_data  = r_data_m;

  function automatic logic [31:0] gen(input int ch, input int n);
    int b;
    b = n % 256;
    if (ch == 1 && peak_mode) return {16'd1, (b == 7 || b == 40) ? 16'd100 : 16'd1};
    return {16'(b), 16'(b)};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive_src();
    s0_valid = (src0_n < src0_tot);
    s1_valid = (src1_n < src1_tot);
    s0_data  = s0_valid ? gen(0, src0_n) : '0;
    s1_data  = s1_valid ? gen(1, src1_n) : '0;
  endtask

  // Observe at the falling edge, advance stimulus just after the rising edge.
  task automatic cycle();
    logic h0, h1;
    @(negedge clk);
    h0 = s0_valid & s0_ready;
    h1 = s1_valid & s1_ready;
    if (rst_n) begin
      if (h0 || h1) hs_cyc.push_back(cyc);
      if (o_valid && i_ready) obs.push_back('{o_data, o_chan, o_idx, o_last, cyc});
      if (peak_valid) begin
        pk_cnt++;
        pk_val  = peak_val;
        pk_idx  = peak_idx;
        pk_chan = peak_chan;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (h0 && rst_n) src0_n++;
    if (h1 && rst_n) src1_n++;
    drive_src();
  endtask

  task automatic clear_obs();
    obs.delete();
    hs_cyc.delete();
    pk_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src0_n = 0; src0_tot = 0; src1_n = 0; src1_tot = 0;
    peak_mode = 1'b0; spur = 1'b0; i_ready = 1'b1;
    drive_src();
    repeat (3) cycle();
    clear_obs();
    rst_n = 1'b1;
  endtask

  task automatic run_until(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (obs.size() < n && k < budget) begin
      cycle();
      k++;
    end
    check(tag, obs.size(), n);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    do_reset();
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_s0_ready", s0_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_err", err, 0);
    check("rst_peak_valid", peak_valid, 0);
    check("rst_peak_val", peak_val, 0);

    // Single channel, two back-to-back frames
    src0_tot = 512;
    drive_src();
    run_until("a_count", 512, 700);
    repeat (3) cycle();
    for (int k = 0; k < obs.size(); k++) begin
      int n;
      n = k % 256;
      check($sformatf("a_chan%0d", k), obs[k].chan, 0);
      check($sformatf("a_idx%0d", k), obs[k].idx, n);
      check($sformatf("a_data%0d", k), obs[k].data, 2 * n * n);
      check($sformatf("a_last%0d", k), obs[k].last, (n == 255));
    end
    if (hs_cyc.size() >= 257) begin
      check("a_rate", hs_cyc[255] - hs_cyc[0], 255);
      check("a_bubble", hs_cyc[256] - hs_cyc[255], 2);
    end else check("a_hs_count", hs_cyc.size(), 512);
    if (obs.size() > 0 && hs_cyc.size() > 0) check("a_latency", obs[0].cyc - hs_cyc[0], 2);
    check("a_pk_cnt", pk_cnt, 2);
    check("a_pk_val", pk_val, 130050);
    check("a_pk_idx", pk_idx, 255);
    check("a_pk_chan", pk_chan, 0);

    // Contention from reset: ch0, ch1, ch0
    do_reset();
    src0_tot = 512;
    src1_tot = 256;
    drive_src();
    run_until("b_count", 768, 1000);
    for (int k = 0; k < obs.size(); k++) begin
      logic ec;
      ec = ((k / 256) == 1);
      check($sformatf("b_chan%0d", k), obs[k].chan, ec);
      check($sformatf("b_idx%0d", k), obs[k].idx, k % 256);
    end

    // Back-pressure mid-frame
    do_reset();
    src0_tot = 256;
    drive_src();
    run_until("c_pre", 50, 200);
    i_ready = 1'b0;
    repeat (20) cycle();
    check("c_buffered", hs_cyc.size() - obs.size(), 4);
    check("c_ready_low", s0_ready, 0);
    check("c_valid_held", o_valid, 1);
    i_ready = 1'b1;
    run_until("c_count", 256, 400);
    for (int k = 0; k < obs.size(); k++) begin
      check($sformatf("c_idx%0d", k), obs[k].idx, k);
      check($sformatf("c_data%0d", k), obs[k].data, 2 * k * k);
    end

    // Peak on ch1: ties at bins 7 and 40, first wins
    do_reset();
    peak_mode = 1'b1;
    src1_tot = 256;
    drive_src();
    run_until("d_count", 256, 400);
    repeat (3) cycle();
    if (obs.size() > 40) begin
      check("d_bin0", obs[0].data, 2);
      check("d_bin7", obs[7].data, 10001);
      check("d_bin40", obs[40].data, 10001);
      check("d_chan", obs[0].chan, 1);
    end
    check("d_pk_cnt", pk_cnt, 1);
    check("d_pk_val", pk_val, 10001);
    check("d_pk_idx", pk_idx, 7);
    check("d_pk_chan", pk_chan, 1);

    // Reset mid-frame at bin 100
    do_reset();
    src0_tot = 512;
    drive_src();
    begin
      int k;
      k = 0;
      while (hs_cyc.size() < 100 && k < 300) begin
        cycle();
        k++;
      end
    end
    check("e_reach100", hs_cyc.size(), 100);
    rst_n = 1'b0;
    cycle();
    check("e_valid", o_valid, 0);
    check("e_data", o_data, 0);
    check("e_idx", o_idx, 0);
    check("e_m_valid", m_valid, 0);
    check("e_s0_ready", s0_ready, 0);
    check("e_err", err, 0);
    check("e_peak_valid", peak_valid, 0);
    clear_obs();
    src0_n = 0; src0_tot = 256;
    src1_n = 0; src1_tot = 256;
    drive_src();
    rst_n = 1'b1;
    run_until("e_count", 256, 400);
    if (obs.size() > 0) begin
      check("e_first_chan", obs[0].chan, 0);
      check("e_first_idx", obs[0].idx, 0);
      check("e_first_data", obs[0].data, 0);
      check("e_last_idx", obs[obs.size()-1].idx, 255);
    end
    check("e_err_after", err, 0);

    // Spurious result with nothing in flight
    do_reset();
    repeat (2) cycle();
    spur = 1'b1;
    cycle();
    spur = 1'b0;
    repeat (5) cycle();
    check("f_no_beat", obs.size(), 0);
    check("f_valid", o_valid, 0);
    check("f_err", err, 1);
    do_reset();
    check("f_err_cleared", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
